// File: rtl/button_events.sv
// button_events
//   Turns the debounced push-button level into one-cycle event pulses
//   (press, release, long-press, auto-repeat). Also keeps a wrapping count
//   of presses. Every output is registered, so an input condition sampled
//   at one clock edge becomes visible in the following cycle.
//
// Parameters
//   LONG_CYCLES   : hold time from press_pulse to long_pulse, in clk cycles (>=2)
//   REPEAT_CYCLES : spacing between repeat pulses after long-press (>=2)
//   CNT_W         : width of press_count
//
// Ports
//   clk           : clock
//   rst           : synchronous active-high reset
//   clean_in      : debounced button level, 1 = pressed, synchronous to clk
//   clr_count     : synchronous clear of press_count
//   press_pulse   : one-cycle pulse on press
//   release_pulse : one-cycle pulse on release
//   long_pulse    : one-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_pulse  : one-cycle pulse every REPEAT_CYCLES after long-press
//   held          : high from the press_pulse cycle until the cycle before release_pulse
//   press_count   : presses since reset/clear, wraps
module button_events #(
    parameter int unsigned LONG_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clean_in,
    input  logic             clr_count,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic             repeat_pulse,
    output logic             held,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [TW-1:0] LONG_T   = TW'(LONG_CYCLES);
    localparam logic [TW-1:0] REPEAT_T = TW'(REPEAT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } state_t;

    state_t           state, state_nx;
    logic [TW-1:0]    timer, timer_nx;
    logic             prev_level;
    logic             rise, fall;
    logic             press_nx, release_nx, long_nx, repeat_nx, held_nx;
    logic [CNT_W-1:0] count_nx;

    assign rise = clean_in & ~prev_level;
    assign fall = ~clean_in & prev_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            prev_level    <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            press_count   <= '0;
        end else begin
            state         <= state_nx;
            timer         <= timer_nx;
            prev_level    <= clean_in;
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
            long_pulse    <= long_nx;
            repeat_pulse  <= repeat_nx;
            held          <= held_nx;
            press_count   <= count_nx;
        end
    end

    // The timer counts the edges since the last press/long/repeat event, so
    // it equals the compare value exactly on the edge where the next pulse is
    // due. Release is tested first so a fall on that edge suppresses the pulse.
    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        long_nx    = 1'b0;
        repeat_nx  = 1'b0;
        held_nx    = held;
        count_nx   = press_count;

        case (state)
            IDLE: begin
                if (rise) begin
                    press_nx = 1'b1;
                    held_nx  = 1'b1;
                    timer_nx = TW'(1);
                    count_nx = press_count + CNT_W'(1);
                    state_nx = PRESSED;
                end
            end
            PRESSED: begin
                if (fall) begin
                    release_nx = 1'b1;
                    held_nx    = 1'b0;
                    timer_nx   = '0;
                    state_nx   = IDLE;
                end else if (clean_in) begin
                    if (timer == LONG_T) begin
                        long_nx  = 1'b1;
                        timer_nx = TW'(1);
                        state_nx = LONG;
                    end else begin
                        timer_nx = timer + TW'(1);
                    end
                end
            end
            LONG: begin
                if (fall) begin
                    release_nx = 1'b1;
                    held_nx    = 1'b0;
                    timer_nx   = '0;
                    state_nx   = IDLE;
                end else if (clean_in) begin
                    if (timer == REPEAT_T) begin
                        repeat_nx = 1'b1;
                        timer_nx  = TW'(1);
                    end else begin
                        timer_nx = timer + TW'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
                held_nx  = 1'b0;
            end
        endcase

        // A clear coinciding with a press leaves the count at that one press.
        if (clr_count) begin
            count_nx = press_nx ? CNT_W'(1) : '0;
        end
    end

endmodule

// File: tb/tb_button_events.sv
// tb_button_events
//   Directed bench for button_events with LONG_CYCLES=8, REPEAT_CYCLES=4,
//   CNT_W=4. A cycle-arithmetic model (press edge index, hold duration) is
//   advanced once per clock edge; outputs are compared on every negedge,
//   and a set of hand-computed literal expectations pins the model.
module tb_button_events;

    localparam int LONG_C = 8;
    localparam int REP_C  = 4;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clean_in = 1'b1;
    logic             clr_count = 1'b0;
    logic             press_pulse, release_pulse, long_pulse, repeat_pulse, held;
    logic [CNT_W-1:0] press_count;

    button_events #(
        .LONG_CYCLES  (LONG_C),
        .REPEAT_CYCLES(REP_C),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clean_in     (clean_in),
        .clr_count    (clr_count),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // model state
    int   m_edge = 0;
    int   m_t0 = 0;
    logic m_pressed = 1'b0;
    logic m_prev = 1'b0;
    int   m_count = 0;
    logic e_press = 1'b0, e_rel = 1'b0, e_long = 1'b0, e_rep = 1'b0, e_held = 1'b0;

    task automatic cmp(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s edge %0d: got %0d expected %0d", nm, m_edge, act, exp);
        end
    endtask

    // Advances the model by one clock edge using the inputs now applied.
    task automatic model_edge();
        logic rise, fall;
        int   d;
        m_edge++;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0;
        if (rst) begin
            m_pressed = 1'b0;
            m_prev    = 1'b0;
            m_count   = 0;
            e_held    = 1'b0;
        end else begin
            rise = clean_in && !m_prev;
            fall = !clean_in && m_prev;
            if (!m_pressed && rise) begin
                e_press   = 1'b1;
                m_pressed = 1'b1;
                m_t0      = m_edge;
                m_count   = (m_count + 1) % (1 << CNT_W);
            end else if (m_pressed && fall) begin
                e_rel     = 1'b1;
                m_pressed = 1'b0;
            end else if (m_pressed && clean_in) begin
                d = m_edge - m_t0;
                if (d == LONG_C)
                    e_long = 1'b1;
                else if (d > LONG_C && ((d - LONG_C) % REP_C) == 0)
                    e_rep = 1'b1;
            end
            if (clr_count) m_count = e_press ? 1 : 0;
            e_held = m_pressed;
            m_prev = clean_in;
        end
    endtask

    task automatic compare_all();
        cmp("press_pulse",   int'(press_pulse),   int'(e_press));
        cmp("release_pulse", int'(release_pulse), int'(e_rel));
        cmp("long_pulse",    int'(long_pulse),    int'(e_long));
        cmp("repeat_pulse",  int'(repeat_pulse),  int'(e_rep));
        cmp("held",          int'(held),          int'(e_held));
        cmp("press_count",   int'(press_count),   m_count);
    endtask

    // Applies inputs for one edge, then checks the outputs that edge produced.
    task automatic step(input logic r, input logic in, input logic clr);
        rst       = r;
        clean_in  = in;
        clr_count = clr;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        // reset with the button already down
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        cmp("lit_rst_held", int'(held), 0);
        cmp("lit_rst_count", int'(press_count), 0);
        cmp("lit_rst_press", int'(press_pulse), 0);

        // first edge after deassert sees a rise
        step(1'b0, 1'b1, 1'b0);
        cmp("lit_post_rst_press", int'(press_pulse), 1);
        cmp("lit_post_rst_held", int'(held), 1);
        cmp("lit_post_rst_count", int'(press_count), 1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        cmp("lit_short_held", int'(held), 1);
        step(1'b0, 1'b0, 1'b0);
        cmp("lit_short_release", int'(release_pulse), 1);
        cmp("lit_short_held_off", int'(held), 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // long hold: long at press+8, repeats at +12, +16, +20
        for (int i = 1; i <= 21; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (i == 9)  cmp("lit_long", int'(long_pulse), 1);
            if (i == 13 || i == 17 || i == 21) cmp("lit_repeat", int'(repeat_pulse), 1);
            if (i == 8 || i == 12) cmp("lit_no_long_early", int'(long_pulse | repeat_pulse), 0);
        end
        step(1'b0, 1'b0, 1'b0);
        cmp("lit_long_release", int'(release_pulse), 1);
        step(1'b0, 1'b0, 1'b0);

        // held exactly LONG_C edges: release wins over long
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        cmp("lit_race_release", int'(release_pulse), 1);
        cmp("lit_race_no_long", int'(long_pulse), 0);
        step(1'b0, 1'b0, 1'b0);
        cmp("lit_race_idle_held", int'(held), 0);

        // 17 one-cycle presses, count starts at 3 and wraps
        for (int i = 1; i <= 17; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (i == 12) cmp("lit_count_15", int'(press_count), 15);
            if (i == 13) cmp("lit_count_wrap0", int'(press_count), 0);
            if (i == 14) cmp("lit_count_wrap1", int'(press_count), 1);
            step(1'b0, 1'b0, 1'b0);
            if (i == 1) cmp("lit_min_release", int'(release_pulse), 1);
        end

        // clear together with a rise, then clear alone
        step(1'b0, 1'b1, 1'b1);
        cmp("lit_clr_rise", int'(press_count), 1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        cmp("lit_clr_alone", int'(press_count), 0);

        // reset in the middle of LONG
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        cmp("lit_midrst_held", int'(held), 0);
        cmp("lit_midrst_release", int'(release_pulse), 0);
        cmp("lit_midrst_count", int'(press_count), 0);
        step(1'b0, 1'b0, 1'b0);
        cmp("lit_midrst_no_release", int'(release_pulse), 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        cmp("lit_after_rst_press", int'(press_pulse), 1);
        cmp("lit_after_rst_count", int'(press_count), 1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
